// File: rtl/stdp_pkg.sv
// Shared types and widths for the STDP weight updater and its arithmetic helper.
package stdp_pkg;

  localparam int SYN_ADDR_W = 16;
  localparam int SYN_DATA_W = 32;
  localparam int WEIGHT_W   = 8;
  localparam int DT_W       = 4;
  localparam int UPD_ADDR_W = 7;
  localparam int CNT_W      = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CALC = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/stdp_delta_calc.sv
// Combinational STDP step: delta = base >> dt, then add/subtract with clipping to [W_MIN, W_MAX].
module stdp_delta_calc
  import stdp_pkg::*;
#(
  parameter logic [WEIGHT_W-1:0] A_PLUS  = 8'd16,
  parameter logic [WEIGHT_W-1:0] A_MINUS = 8'd12,
  parameter logic [WEIGHT_W-1:0] W_MAX   = 8'd255,
  parameter logic [WEIGHT_W-1:0] W_MIN   = 8'd0
) (
  input  logic [WEIGHT_W-1:0] w,
  input  logic                ltp,
  input  logic [DT_W-1:0]     dt,
  output logic [WEIGHT_W-1:0] new_w,
  output logic                sat
);

  logic [WEIGHT_W-1:0] delta_s;
  logic [WEIGHT_W:0]   sum_s;
  logic [WEIGHT_W:0]   floor_s;

  // Shift the base step and clip the result; 9-bit sums keep the carry visible.
  always_comb begin
    delta_s = (ltp ? A_PLUS : A_MINUS) >> dt;
    sum_s   = {1'b0, w} + {1'b0, delta_s};
    floor_s = {1'b0, W_MIN} + {1'b0, delta_s};
    new_w   = w;
    sat     = 1'b0;
    if (ltp) begin
      if (sum_s > {1'b0, W_MAX}) begin
        new_w = W_MAX;
        sat   = 1'b1;
      end else begin
        new_w = sum_s[WEIGHT_W-1:0];
        sat   = 1'b0;
      end
    end else begin
      if ({1'b0, w} < floor_s) begin
        new_w = W_MIN;
        sat   = 1'b1;
      end else begin
        new_w = w - delta_s;
        sat   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/stdp_weight_updater.sv
// Read-modify-write initiator for one synapse weight byte per STDP update request.
module stdp_weight_updater
  import stdp_pkg::*;
#(
  parameter logic [WEIGHT_W-1:0] A_PLUS  = 8'd16,
  parameter logic [WEIGHT_W-1:0] A_MINUS = 8'd12,
  parameter logic [WEIGHT_W-1:0] W_MAX   = 8'd255,
  parameter logic [WEIGHT_W-1:0] W_MIN   = 8'd0,
  parameter logic [DT_W-1:0]     DT_WIN  = 4'd8,
  parameter int                  RD_LAT  = 2,
  parameter int                  WR_HOLD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [UPD_ADDR_W-1:0] upd_addr,
  input  logic                  upd_ltp,
  input  logic [DT_W-1:0]       upd_dt,
  output logic [SYN_ADDR_W-1:0] syn_addr,
  output logic [SYN_DATA_W-1:0] syn_wdata,
  output logic                  syn_r_en,
  output logic                  syn_w_en,
  input  logic [WEIGHT_W-1:0]   syn_weight_in,
  output logic                  upd_done,
  output logic                  upd_sat,
  output logic                  busy
);

  state_e                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [UPD_ADDR_W-1:0] addr_r;
  logic                  ltp_r;
  logic [DT_W-1:0]       dt_r;
  logic                  sat_r;
  logic                  accept_s;
  logic [UPD_ADDR_W-1:0] cur_addr_s;
  logic [WEIGHT_W-1:0]   new_w_s;
  logic                  calc_sat_s;
  logic                  ready_s, busy_s, r_en_s, w_en_s, done_s, sat_s;
  logic [SYN_ADDR_W-1:0] addr_s;
  logic [SYN_DATA_W-1:0] wdata_s;

  // upd_ready is high exactly in IDLE, so a valid request in IDLE is accepted.
  assign accept_s   = (state_r == IDLE) && upd_valid;
  assign cur_addr_s = (state_r == IDLE) ? upd_addr : addr_r;

  stdp_delta_calc #(
    .A_PLUS (A_PLUS),
    .A_MINUS(A_MINUS),
    .W_MAX  (W_MAX),
    .W_MIN  (W_MIN)
  ) u_delta_calc (
    .w    (syn_weight_in),
    .ltp  (ltp_r),
    .dt   (dt_r),
    .new_w(new_w_s),
    .sat  (calc_sat_s)
  );

  // State register, per-state hold counter and captured request fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      addr_r  <= {UPD_ADDR_W{1'b0}};
      ltp_r   <= 1'b0;
      dt_r    <= {DT_W{1'b0}};
      sat_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r) cnt_r <= {CNT_W{1'b0}};
      else                    cnt_r <= cnt_r + CNT_W'(1);
      if (accept_s) begin
        addr_r <= upd_addr;
        ltp_r  <= upd_ltp;
        dt_r   <= upd_dt;
      end
      if (state_r == CALC) sat_r <= calc_sat_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (upd_valid) state_s = (upd_dt >= DT_WIN) ? DONE : RD;
        else           state_s = IDLE;
      end
      RD: begin
        if (cnt_r == CNT_W'(RD_LAT - 1)) state_s = CALC;
        else                             state_s = RD;
      end
      CALC: state_s = WR;
      WR: begin
        if (cnt_r == CNT_W'(WR_HOLD - 1)) state_s = DONE;
        else                              state_s = WR;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with the state they belong to.
  always_comb begin
    ready_s = 1'b0;
    busy_s  = 1'b0;
    r_en_s  = 1'b0;
    w_en_s  = 1'b0;
    done_s  = 1'b0;
    sat_s   = 1'b0;
    addr_s  = {SYN_ADDR_W{1'b0}};
    wdata_s = {SYN_DATA_W{1'b0}};
    case (state_s)
      IDLE: ready_s = 1'b1;
      RD: begin
        busy_s = 1'b1;
        r_en_s = 1'b1;
        addr_s = {{(SYN_ADDR_W-UPD_ADDR_W){1'b0}}, cur_addr_s};
      end
      CALC: begin
        busy_s = 1'b1;
        addr_s = {{(SYN_ADDR_W-UPD_ADDR_W){1'b0}}, cur_addr_s};
      end
      WR: begin
        busy_s  = 1'b1;
        w_en_s  = 1'b1;
        addr_s  = {{(SYN_ADDR_W-UPD_ADDR_W){1'b0}}, cur_addr_s};
        wdata_s = (state_r == CALC) ? {{(SYN_DATA_W-WEIGHT_W){1'b0}}, new_w_s} : syn_wdata;
      end
      DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
        sat_s  = (state_r == WR) ? sat_r : 1'b0;
      end
      default: ready_s = 1'b0;
    endcase
  end

  // Registered outputs; reset drops any in-flight enable immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_ready <= 1'b1;
      busy      <= 1'b0;
      syn_r_en  <= 1'b0;
      syn_w_en  <= 1'b0;
      upd_done  <= 1'b0;
      upd_sat   <= 1'b0;
      syn_addr  <= {SYN_ADDR_W{1'b0}};
      syn_wdata <= {SYN_DATA_W{1'b0}};
    end else begin
      upd_ready <= ready_s;
      busy      <= busy_s;
      syn_r_en  <= r_en_s;
      syn_w_en  <= w_en_s;
      upd_done  <= done_s;
      upd_sat   <= sat_s;
      syn_addr  <= addr_s;
      syn_wdata <= wdata_s;
    end
  end

endmodule

// File: tb/tb_stdp_weight_updater.sv
// Self-checking bench: synapse memory model plus a plain-arithmetic STDP reference.
module tb_stdp_weight_updater;

  localparam int RD_LAT  = 2;
  localparam int WR_HOLD = 2;
  localparam int LAT     = RD_LAT + 1 + WR_HOLD + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid;
  logic        upd_ready;
  logic [6:0]  upd_addr;
  logic        upd_ltp;
  logic [3:0]  upd_dt;
  logic [15:0] syn_addr;
  logic [31:0] syn_wdata;
  logic        syn_r_en;
  logic        syn_w_en;
  logic [7:0]  syn_weight_in;
  logic        upd_done;
  logic        upd_sat;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [0:127];
  logic [7:0] syn_mem [0:127];
  logic       load_mem = 1'b0;
  logic [6:0] rd_addr_d;
  int         wcnt = 0;

  always #5 clk = ~clk;

  stdp_weight_updater dut (
    .clk          (clk),
    .rst          (rst),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_addr     (upd_addr),
    .upd_ltp      (upd_ltp),
    .upd_dt       (upd_dt),
    .syn_addr     (syn_addr),
    .syn_wdata    (syn_wdata),
    .syn_r_en     (syn_r_en),
    .syn_w_en     (syn_w_en),
    .syn_weight_in(syn_weight_in),
    .upd_done     (upd_done),
    .upd_sat      (upd_sat),
    .busy         (busy)
  );

  // Synapse model: 1 cycle address decode, 1 cycle registered read; a write lands after WR_HOLD cycles of W_EN.
  always @(posedge clk) begin
    rd_addr_d     <= syn_addr[6:0];
    syn_weight_in <= syn_mem[rd_addr_d];
    if (load_mem) begin
      syn_mem <= ref_mem;
      wcnt    <= 0;
    end else if (syn_w_en) begin
      if (wcnt == WR_HOLD - 1) begin
        syn_mem[syn_addr[6:0]] <= syn_wdata[7:0];
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  function automatic void ref_update(input int w, input bit ltp, input int dt,
                                     output int nw, output bit sat);
    int step;
    step = (ltp ? 16 : 12) >> dt;
    if (ltp) nw = w + step;
    else     nw = w - step;
    sat = 1'b0;
    if (nw > 255) begin nw = 255; sat = 1'b1; end
    if (nw < 0)   begin nw = 0;   sat = 1'b1; end
  endfunction

  task automatic set_w(input int a, input int w);
    ref_mem[a] = w[7:0];
    @(negedge clk) load_mem = 1'b1;
    @(negedge clk) load_mem = 1'b0;
  endtask

  // Issue one request at a negedge in IDLE and check every cycle until the updater is back in IDLE.
  task automatic run_req(input int a, input bit ltp, input int dt, input bit hold);
    int nw;
    bit sat, in_win, exp_r, exp_w, exp_done, exp_ready, exp_busy;
    int lat;
    in_win = (dt < 8);
    ref_update(int'(ref_mem[a]), ltp, dt, nw, sat);
    lat = in_win ? LAT : 1;
    checks++;
    if (upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_req addr=%0d: got %b want 1", a, upd_ready);
    end
    upd_addr  = a[6:0];
    upd_ltp   = ltp;
    upd_dt    = dt[3:0];
    upd_valid = 1'b1;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (hold) begin
        upd_addr = 7'($urandom);
        upd_ltp  = 1'($urandom);
        upd_dt   = 4'($urandom);
      end else begin
        upd_valid = 1'b0;
      end
      exp_r     = in_win && (k <= RD_LAT);
      exp_w     = in_win && (k >= RD_LAT + 2) && (k <= RD_LAT + 1 + WR_HOLD);
      exp_done  = (k == lat);
      exp_ready = (k == lat + 1);
      exp_busy  = (k <= lat);
      checks++;
      if ({syn_r_en, syn_w_en, upd_done, upd_ready, busy} !==
          {exp_r, exp_w, exp_done, exp_ready, exp_busy}) begin
        errors++;
        $display("FAIL ctrl addr=%0d dt=%0d cycle=%0d: got r/w/done/rdy/busy=%b%b%b%b%b want %b%b%b%b%b",
                 a, dt, k, syn_r_en, syn_w_en, upd_done, upd_ready, busy,
                 exp_r, exp_w, exp_done, exp_ready, exp_busy);
      end
      if (in_win && k <= RD_LAT + 1 + WR_HOLD) begin
        checks++;
        if (syn_addr !== 16'(a)) begin
          errors++;
          $display("FAIL syn_addr cycle=%0d: got %0d want %0d", k, syn_addr, a);
        end
      end
      if (exp_w) begin
        checks++;
        if (syn_wdata !== 32'(nw)) begin
          errors++;
          $display("FAIL wdata addr=%0d ltp=%0d dt=%0d: got %08h want %08h", a, ltp, dt, syn_wdata, 32'(nw));
        end
      end
      if (exp_done) begin
        checks++;
        if (upd_sat !== (in_win && sat)) begin
          errors++;
          $display("FAIL upd_sat addr=%0d ltp=%0d dt=%0d: got %b want %b", a, ltp, dt, upd_sat, in_win && sat);
        end
      end
    end
    if (in_win) ref_mem[a] = nw[7:0];
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({upd_ready, busy, upd_done, upd_sat, syn_r_en, syn_w_en} !== 6'b100000 ||
        syn_addr !== 16'h0000 || syn_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got rdy/busy/done/sat/r/w=%b%b%b%b%b%b addr=%h wdata=%h want 100000 0 0",
               upd_ready, busy, upd_done, upd_sat, syn_r_en, syn_w_en, syn_addr, syn_wdata);
    end
  endtask

  task automatic test_ltp_basic();
    set_w(5, 100);
    run_req(5, 1'b1, 1, 1'b0);
  endtask

  task automatic test_saturation();
    set_w(20, 250);
    run_req(20, 1'b1, 0, 1'b0);
    set_w(21, 5);
    run_req(21, 1'b0, 0, 1'b0);
  endtask

  task automatic test_out_of_window();
    run_req(30, 1'b1, 9, 1'b0);
    run_req(31, 1'b0, 15, 1'b0);
    run_req(32, 1'b1, 8, 1'b0);
    run_req(33, 1'b0, 7, 1'b0);
  endtask

  task automatic test_zero_delta();
    set_w(40, 255);
    run_req(40, 1'b1, 5, 1'b0);
    run_req(41, 1'b0, 4, 1'b0);
  endtask

  task automatic test_addr_wrap();
    set_w(127, 200);
    run_req(127, 1'b0, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_req(int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 9)), 1'b1);
    upd_valid = 1'b0;
  endtask

  task automatic test_reset_during_wr();
    set_w(9, 40);
    upd_addr  = 7'd9;
    upd_ltp   = 1'b1;
    upd_dt    = 4'd2;
    upd_valid = 1'b1;
    @(negedge clk) upd_valid = 1'b0;
    repeat (RD_LAT + 1) @(negedge clk);
    checks++;
    if (syn_w_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_w_en: got %b want 1", syn_w_en);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({syn_w_en, syn_r_en, upd_ready, upd_done, busy} !== 5'b00100) begin
      errors++;
      $display("FAIL async_reset_in_wr: got w/r/rdy/done/busy=%b%b%b%b%b want 00100",
               syn_w_en, syn_r_en, upd_ready, upd_done, busy);
    end
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (upd_done !== 1'b0 || syn_w_en !== 1'b0) begin
        errors++;
        $display("FAIL after_reset_quiet cycle=%0d: got done=%b w_en=%b want 0 0", k, upd_done, syn_w_en);
      end
    end
    run_req(9, 1'b1, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_req(int'($urandom_range(0, 127)), 1'($urandom), int'($urandom_range(0, 10)), 1'($urandom));
      upd_valid = 1'b0;
    end
  endtask

  task automatic test_memory_image();
    repeat (3) @(negedge clk);
    for (int a = 0; a < 128; a++) begin
      checks++;
      if (syn_mem[a] !== ref_mem[a]) begin
        errors++;
        $display("FAIL mem_image addr=%0d: got %0d want %0d", a, syn_mem[a], ref_mem[a]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    upd_valid = 1'b0;
    upd_addr  = 7'd0;
    upd_ltp   = 1'b0;
    upd_dt    = 4'd0;
    for (int a = 0; a < 128; a++) ref_mem[a] = 8'($urandom);
    @(negedge clk) load_mem = 1'b1;
    @(negedge clk) load_mem = 1'b0;
    test_reset();
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    test_ltp_basic();
    test_saturation();
    test_out_of_window();
    test_zero_delta();
    test_addr_wrap();
    test_back_to_back();
    test_reset_during_wr();
    test_random();
    test_memory_image();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
